// File: rtl/nbin_unpacker_array_pkg.sv
// rtl/nbin_unpacker_array_pkg.sv - shared defaults and width helpers for the NBin unpacker array
package nbin_unpacker_array_pkg;

    localparam int DEF_BIT_WIDTH  = 16;
    localparam int DEF_N_LANES    = 16;
    localparam int DEF_SHIFT_BITS = 5;

    // bits_avail spans 0..2*BIT_WIDTH inclusive
    function automatic int cnt_width(input int bit_width);
        return $clog2(2 * bit_width + 1);
    endfunction

endpackage

// File: rtl/nbin_lane_unpacker.sv
// rtl/nbin_lane_unpacker.sv - one lane: bit buffer, word placement, extract, extend, shift
module nbin_lane_unpacker
    import nbin_unpacker_array_pkg::*;
#(
    parameter int BIT_WIDTH  = DEF_BIT_WIDTH,
    parameter int SHIFT_BITS = DEF_SHIFT_BITS,
    parameter int CNT_W      = cnt_width(DEF_BIT_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [BIT_WIDTH-1:0]  word,
    input  logic [CNT_W-1:0]      place,
    input  logic [SHIFT_BITS-1:0] prec,
    input  logic                  is_signed,
    input  logic [SHIFT_BITS-2:0] frac,
    output logic [BIT_WIDTH-1:0]  out
);

    logic [2*BIT_WIDTH-1:0] buf_q;
    logic [2*BIT_WIDTH-1:0] shifted;
    logic [2*BIT_WIDTH-1:0] placed;
    logic [2*BIT_WIDTH-1:0] buf_d;
    logic [BIT_WIDTH-1:0]   ones;
    logic [BIT_WIDTH-1:0]   mask;
    logic [BIT_WIDTH-1:0]   low;
    logic [BIT_WIDTH-1:0]   ext;
    logic [SHIFT_BITS-1:0]  sign_idx;
    logic                   sign_bit;

    assign ones     = '1;
    assign shifted  = pop ? (buf_q >> prec) : buf_q;
    assign placed   = {{BIT_WIDTH{1'b0}}, word} << place;
    assign buf_d    = push ? (shifted | placed) : shifted;

    // Buffer bits above bits_avail are always zero, so OR-placement is safe
    assign mask     = ones >> (SHIFT_BITS'(BIT_WIDTH) - prec);
    assign low      = buf_q[BIT_WIDTH-1:0] & mask;
    assign sign_idx = prec - 1'b1;
    assign sign_bit = is_signed & buf_q[sign_idx];
    assign ext      = sign_bit ? (low | ~mask) : low;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q <= '0;
            out   <= '0;
        end else begin
            buf_q <= flush ? '0 : buf_d;
            if (pop) begin
                out <= ext << frac;
            end
        end
    end

endmodule

// File: rtl/nbin_unpacker_array.sv
// rtl/nbin_unpacker_array.sv - multi-lane streaming NBin unpacker with shared control path
module nbin_unpacker_array
    import nbin_unpacker_array_pkg::*;
#(
    parameter int BIT_WIDTH  = DEF_BIT_WIDTH,
    parameter int N_LANES    = DEF_N_LANES,
    parameter int SHIFT_BITS = DEF_SHIFT_BITS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_cfg_we,
    input  logic [SHIFT_BITS-1:0]        i_prec,
    input  logic                         i_signed,
    input  logic [SHIFT_BITS-2:0]        i_frac,
    input  logic                         i_flush,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [N_LANES*BIT_WIDTH-1:0] i_in,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [N_LANES*BIT_WIDTH-1:0] o_out,
    output logic                         o_busy,
    output logic                         o_cfg_err
);

    localparam int CNT_W = cnt_width(BIT_WIDTH);

    logic [CNT_W-1:0]      bits_avail;
    logic [CNT_W-1:0]      prec_ext;
    logic [CNT_W-1:0]      place;
    logic [SHIFT_BITS-1:0] prec_q;
    logic [SHIFT_BITS-1:0] prec_in;
    logic                  signed_q;
    logic [SHIFT_BITS-2:0] frac_q;
    logic                  push;
    logic                  pop;

    assign prec_ext = CNT_W'(prec_q);
    assign o_ready  = (bits_avail <= CNT_W'(BIT_WIDTH)) && !i_flush;
    assign push     = i_valid && o_ready;
    assign pop      = (bits_avail >= prec_ext) && (!o_valid || i_ready) && !i_flush;
    assign o_busy   = (bits_avail != '0) || o_valid;
    assign place    = pop ? (bits_avail - prec_ext) : bits_avail;

    // Out-of-range precision folds to full width
    assign prec_in  = ((i_prec == '0) || (i_prec > SHIFT_BITS'(BIT_WIDTH)))
                      ? SHIFT_BITS'(BIT_WIDTH) : i_prec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bits_avail <= '0;
            prec_q     <= SHIFT_BITS'(BIT_WIDTH);
            signed_q   <= 1'b0;
            frac_q     <= '0;
            o_valid    <= 1'b0;
            o_cfg_err  <= 1'b0;
        end else begin
            o_cfg_err <= 1'b0;
            if (i_cfg_we) begin
                if (o_busy) begin
                    o_cfg_err <= 1'b1;
                end else begin
                    prec_q   <= prec_in;
                    signed_q <= i_signed;
                    frac_q   <= i_frac;
                end
            end
            if (i_flush) begin
                bits_avail <= '0;
            end else begin
                bits_avail <= bits_avail - (pop ? prec_ext : '0)
                                         + (push ? CNT_W'(BIT_WIDTH) : '0);
            end
            if (pop) begin
                o_valid <= 1'b1;
            end else if (i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        nbin_lane_unpacker #(
            .BIT_WIDTH (BIT_WIDTH),
            .SHIFT_BITS(SHIFT_BITS),
            .CNT_W     (CNT_W)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .push     (push),
            .pop      (pop),
            .flush    (i_flush),
            .word     (i_in[k*BIT_WIDTH +: BIT_WIDTH]),
            .place    (place),
            .prec     (prec_q),
            .is_signed(signed_q),
            .frac     (frac_q),
            .out      (o_out[k*BIT_WIDTH +: BIT_WIDTH])
        );
    end

endmodule
